ems_mapper: RTL and testbench

Parametrised EMS page mapper for the Zet SoC: maps a UMB page-frame window of `NUM_PAGES` pages of 2^`PAGE_BITS` bytes each onto physical SDRAM pages. It adds several things to the four-page, 16KB, 8MB-limited mapper:
- an indexed page-register file with auto-increment;
- full 16-bit Wishbone access with byte lanes;
- an "unmapped" page code that raises a fault;
- a registered translation stage with a request/acknowledge handshake.

The block sits between the CPU-side memory address path and the SDRAM controller, and is programmed through the I/O Wishbone bus.

---
 rtl/ems_mapper_pkg.sv | 31 +++
 rtl/ems_mapper_if.sv | 37 +++
 rtl/ems_mapper_page_file.sv | 64 ++++++
 rtl/ems_mapper.sv | 152 +++++++++++++++
 tb/tb_ems_mapper.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ems_mapper_pkg.sv
// ems_pkg: shared constants for the EMS page mapper.
//   REG_*          register offsets on the I/O Wishbone bus (wb_adr_i[2:1])
//   CTRL_EN_BIT    enable bit position in CTRL
//   INDEX_AI_BIT   auto-increment bit position in INDEX
//   VERSION        value reported in ID[15:12]
//   unmapped_pfn() all-ones PFN code for a given PFN width
package ems_pkg;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_INDEX = 2'd1;
  localparam logic [1:0] REG_DATA  = 2'd2;
  localparam logic [1:0] REG_ID    = 2'd3;

  localparam int CTRL_EN_BIT  = 15;
  localparam int INDEX_AI_BIT = 7;

  localparam logic [3:0] VERSION = 4'd2;

  localparam int PFN_MAX_W = 15;

  // Low pfn_w bits set; callers cast down to their own PFN width.
  function automatic logic [PFN_MAX_W-1:0] unmapped_pfn(input int pfn_w);
    logic [PFN_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < PFN_MAX_W; i++) begin
      if (i < pfn_w) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/ems_mapper_if.sv
// ems_mapper_if: bundles the I/O Wishbone programming port and the
// translation request/result port of the EMS mapper.
//   wb_*   16-bit Wishbone slave (register select, data, byte lanes, ack)
//   tr_*   translation request (CPU word address) and registered result
// Modports: master = CPU/bus side, slave = mapper.
interface ems_mapper_if;

  logic [2:1]  wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  logic        tr_req_i;
  logic [19:1] tr_adr_i;
  logic        tr_ack_o;
  logic [31:0] tr_adr_o;
  logic        tr_fault_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o,
    output tr_req_i, tr_adr_i,
    input  tr_ack_o, tr_adr_o, tr_fault_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o,
    input  tr_req_i, tr_adr_i,
    output tr_ack_o, tr_adr_o, tr_fault_o
  );

endinterface

// File: rtl/ems_mapper_page_file.sv
// ems_page_file: page-number registers of the EMS mapper plus the
// INDEX/AI pointer used to reach them through the DATA register.
//   clk, rst    clock, synchronous active-high reset
//   index_we    INDEX register write strobe (lane 0 carries index and AI)
//   data_we     DATA write strobe into page[index]
//   data_acc    any acknowledged DATA access; drives auto-increment
//   wdata, sel  write data and byte lanes
//   index, ai   current pointer and auto-increment flag
//   page_rd     page[index] for DATA reads
//   tr_idx      page select from the translation path
//   tr_pfn      page[tr_idx]
module ems_page_file
  import ems_pkg::*;
#(
  parameter int NUM_PAGES = 4,
  parameter int PFN_W     = 9,
  localparam int IDX_W    = $clog2(NUM_PAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             index_we,
  input  logic             data_we,
  input  logic             data_acc,
  input  logic [15:0]      wdata,
  input  logic [1:0]       sel,
  output logic [IDX_W-1:0] index,
  output logic             ai,
  output logic [PFN_W-1:0] page_rd,
  input  logic [IDX_W-1:0] tr_idx,
  output logic [PFN_W-1:0] tr_pfn
);

  logic [PFN_W-1:0] pages [NUM_PAGES];
  logic [15:0]      merged16;
  logic [PFN_W-1:0] merged;

  assign page_rd = pages[index];
  assign tr_pfn  = pages[tr_idx];

  // Byte-lane merge over the current page; bits above PFN_W are dropped.
  always_comb begin
    merged16 = 16'(pages[index]);
    if (sel[0]) merged16[7:0]  = wdata[7:0];
    if (sel[1]) merged16[15:8] = wdata[15:8];
    merged = merged16[PFN_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PAGES; i++) pages[i] <= PFN_W'(i);
      index <= '0;
      ai    <= 1'b0;
    end else begin
      if (index_we && sel[0]) begin
        index <= wdata[IDX_W-1:0];
        ai    <= wdata[INDEX_AI_BIT];
      end
      if (data_we) pages[index] <= merged;
      // NUM_PAGES is a power of two, so the natural overflow is the wrap.
      if (data_acc && ai) index <= index + IDX_W'(1);
    end
  end

endmodule

// File: rtl/ems_mapper.sv
// ems_mapper: EMS page-frame mapper. Translates CPU addresses falling in
// a NUM_PAGES x 2^PAGE_BITS window onto SDRAM pages, programmed through
// a 16-bit I/O Wishbone slave.
//   wb_clk  only clock
//   wb_rst  synchronous active-high reset
//   bus     ems_mapper_if.slave: Wishbone registers CTRL/INDEX/DATA/ID and
//           the 1-cycle registered translation port (tr_*)
module ems_mapper
  import ems_pkg::*;
#(
  parameter int NUM_PAGES  = 4,
  parameter int PAGE_BITS  = 14,
  parameter int PHYS_ADR_W = 23
) (
  input  logic         wb_clk,
  input  logic         wb_rst,
  ems_mapper_if.slave  bus
);

  localparam int IDX_W    = $clog2(NUM_PAGES);
  localparam int WIN_BITS = PAGE_BITS + IDX_W;
  localparam int BASE_W   = 20 - WIN_BITS;
  localparam int PFN_W    = PHYS_ADR_W - PAGE_BITS;
  localparam logic [PFN_W-1:0] UNMAPPED = PFN_W'(unmapped_pfn(PFN_W));

  logic              en;
  logic [BASE_W-1:0] base;
  logic              ack_q;
  logic              access;
  logic              wr;
  logic              index_we;
  logic              data_we;
  logic              data_acc;
  logic [IDX_W-1:0]  index;
  logic              ai;
  logic [PFN_W-1:0]  page_rd;
  logic [IDX_W-1:0]  tr_idx;
  logic [PFN_W-1:0]  tr_pfn;
  logic              in_win;
  logic [31:0]       adr_d;
  logic              fault_d;
  logic              tr_ack_q;
  logic [31:0]       tr_adr_q;
  logic              tr_fault_q;
  logic [15:0]       rdata;
  logic              unused_adr_bit;

  // The SDRAM side is 32-bit word addressed; the half-word select is
  // not carried into the translated address.
  assign unused_adr_bit = bus.tr_adr_i[1];

  // Wishbone: one access per strobe, ack on the following cycle.
  assign access   = bus.wb_cyc_i && bus.wb_stb_i && !ack_q;
  assign wr       = access && bus.wb_we_i;
  assign index_we = wr && (bus.wb_adr_i == REG_INDEX);
  assign data_we  = wr && (bus.wb_adr_i == REG_DATA) && (bus.wb_sel_i != 2'b00);
  assign data_acc = access && (bus.wb_adr_i == REG_DATA);

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      ack_q <= 1'b0;
      en    <= 1'b0;
      base  <= '0;
    end else begin
      ack_q <= access;
      if (wr && (bus.wb_adr_i == REG_CTRL)) begin
        if (bus.wb_sel_i[0]) base <= bus.wb_dat_i[BASE_W-1:0];
        if (bus.wb_sel_i[1]) en   <= bus.wb_dat_i[CTRL_EN_BIT];
      end
    end
  end

  ems_page_file #(
    .NUM_PAGES (NUM_PAGES),
    .PFN_W     (PFN_W)
  ) u_page_file (
    .clk      (wb_clk),
    .rst      (wb_rst),
    .index_we (index_we),
    .data_we  (data_we),
    .data_acc (data_acc),
    .wdata    (bus.wb_dat_i),
    .sel      (bus.wb_sel_i),
    .index    (index),
    .ai       (ai),
    .page_rd  (page_rd),
    .tr_idx   (tr_idx),
    .tr_pfn   (tr_pfn)
  );

  always_comb begin
    rdata = '0;
    case (bus.wb_adr_i)
      REG_CTRL: begin
        rdata[CTRL_EN_BIT]  = en;
        rdata[BASE_W-1:0]   = base;
      end
      REG_INDEX: begin
        rdata[IDX_W-1:0]    = index;
        rdata[INDEX_AI_BIT] = ai;
      end
      REG_DATA: begin
        rdata[PFN_W-1:0]    = page_rd;
      end
      default: begin
        rdata[4:0]   = 5'(NUM_PAGES);
        rdata[11:8]  = 4'(PAGE_BITS - 12);
        rdata[15:12] = VERSION;
      end
    endcase
  end

  assign bus.wb_dat_o = rdata;
  assign bus.wb_ack_o = ack_q;

  // Translation: page registers and CTRL are read before any write on the
  // same edge lands, so a concurrent write only affects later requests.
  assign tr_idx = bus.tr_adr_i[WIN_BITS-1:PAGE_BITS];
  assign in_win = en && (bus.tr_adr_i[19:WIN_BITS] == base);

  always_comb begin
    fault_d = 1'b0;
    adr_d   = 32'({bus.tr_adr_i[19:2], 2'b00});
    if (in_win) begin
      if (tr_pfn == UNMAPPED) begin
        fault_d = 1'b1;
        adr_d   = '0;
      end else begin
        adr_d = 32'({tr_pfn, bus.tr_adr_i[PAGE_BITS-1:2], 2'b00});
      end
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      tr_ack_q   <= 1'b0;
      tr_adr_q   <= '0;
      tr_fault_q <= 1'b0;
    end else begin
      tr_ack_q <= bus.tr_req_i;
      if (bus.tr_req_i) begin
        tr_adr_q   <= adr_d;
        tr_fault_q <= fault_d;
      end
    end
  end

  assign bus.tr_ack_o   = tr_ack_q;
  assign bus.tr_adr_o   = tr_adr_q;
  assign bus.tr_fault_o = tr_fault_q;

endmodule

// File: tb/tb_ems_mapper.sv
module tb_ems_mapper;
  import ems_pkg::*;

  logic wb_clk;
  logic wb_rst;
  int   n_cmp;
  int   n_bad;
  logic [15:0] rd;

  ems_mapper_if bus ();

  ems_mapper #(
    .NUM_PAGES  (4),
    .PAGE_BITS  (14),
    .PHYS_ADR_W (23)
  ) dut (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .bus    (bus)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after an edge; returns at #1 after the edge where ack drops.
  task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [15:0] dat,
                         input logic [1:0] sel, output logic [15:0] rdat);
    logic got;
    got  = 1'b0;
    rdat = '0;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge wb_clk); #1;
      if (bus.wb_ack_o) begin
        got  = 1'b1;
        rdat = bus.wb_dat_o;
      end
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    n_cmp++;
    assert (got === 1'b1) else begin
      n_bad++;
      $error("FAIL wb_ack_timeout: observed %0b expected 1", got);
    end
    @(posedge wb_clk); #1;
  endtask

  task automatic wr(input logic [1:0] adr, input logic [15:0] dat, input logic [1:0] sel);
    logic [15:0] dummy;
    wb_xfer(1'b1, adr, dat, sel, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] adr, input logic [15:0] exp);
    logic [15:0] v;
    wb_xfer(1'b0, adr, 16'h0, 2'b11, v);
    chk(tag, 32'(v), 32'(exp));
  endtask

  task automatic translate(input string tag, input logic [19:0] ba,
                           input logic [31:0] exp_adr, input logic exp_fault);
    bus.tr_req_i = 1'b1;
    bus.tr_adr_i = ba[19:1];
    @(posedge wb_clk); #1;
    bus.tr_req_i = 1'b0;
    chk({tag, "_ack"},   32'(bus.tr_ack_o),   32'd1);
    chk({tag, "_adr"},   bus.tr_adr_o,        exp_adr);
    chk({tag, "_fault"}, 32'(bus.tr_fault_o), 32'(exp_fault));
  endtask

  initial begin
    logic [19:0] ba;
    n_cmp = 0;
    n_bad = 0;
    wb_rst = 1'b1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 2'd0;
    bus.wb_dat_i = 16'h0;
    bus.wb_sel_i = 2'b00;
    bus.tr_req_i = 1'b0;
    bus.tr_adr_i = '0;
    repeat (3) @(posedge wb_clk);
    #1 wb_rst = 1'b0;

    chk("rst_wb_ack",   32'(bus.wb_ack_o),   32'd0);
    chk("rst_tr_ack",   32'(bus.tr_ack_o),   32'd0);
    chk("rst_tr_adr",   bus.tr_adr_o,        32'd0);
    chk("rst_tr_fault", 32'(bus.tr_fault_o), 32'd0);

    rd_chk("id", REG_ID, 16'h2204);
    rd_chk("ctrl_rst", REG_CTRL, 16'h0000);
    rd_chk("index_rst", REG_INDEX, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      wr(REG_INDEX, 16'(i), 2'b11);
      rd_chk($sformatf("page_rst_%0d", i), REG_DATA, 16'(i));
    end
    translate("tr_disabled", 20'hD0000, 32'h000D0000, 1'b0);
    @(posedge wb_clk); #1;
    chk("tr_idle_ack",  32'(bus.tr_ack_o), 32'd0);
    chk("tr_idle_hold", bus.tr_adr_o,      32'h000D0000);

    // Held strobe: one ack every second cycle.
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = REG_ID;
    @(posedge wb_clk); #1; chk("held_ack_1", 32'(bus.wb_ack_o), 32'd1);
    @(posedge wb_clk); #1; chk("held_ack_2", 32'(bus.wb_ack_o), 32'd0);
    @(posedge wb_clk); #1; chk("held_ack_3", 32'(bus.wb_ack_o), 32'd1);
    @(posedge wb_clk); #1; chk("held_ack_4", 32'(bus.wb_ack_o), 32'd0);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    @(posedge wb_clk); #1;

    wr(REG_CTRL, 16'h800D, 2'b11);
    rd_chk("ctrl_set", REG_CTRL, 16'h800D);
    wr(REG_INDEX, 16'h0002, 2'b11);
    wr(REG_DATA, 16'h01F5, 2'b11);
    translate("tr_page2", 20'hD8010, 32'h007D4010, 1'b0);

    // Auto-increment with wrap from 3 to 0.
    wr(REG_INDEX, 16'h0083, 2'b11);
    wr(REG_DATA, 16'h0010, 2'b11);
    wr(REG_DATA, 16'h0011, 2'b11);
    wr(REG_DATA, 16'h0012, 2'b11);
    wr(REG_DATA, 16'h0013, 2'b11);
    rd_chk("index_ai_wrap", REG_INDEX, 16'h0083);
    wr(REG_INDEX, 16'h0003, 2'b11);
    rd_chk("ai_page3", REG_DATA, 16'h0010);
    wr(REG_INDEX, 16'h0000, 2'b11);
    rd_chk("ai_page0", REG_DATA, 16'h0011);
    wr(REG_INDEX, 16'h0001, 2'b11);
    rd_chk("ai_page1", REG_DATA, 16'h0012);
    wr(REG_INDEX, 16'h0002, 2'b11);
    rd_chk("ai_page2", REG_DATA, 16'h0013);
    translate("tr_page3", 20'hDC008, 32'h00040008, 1'b0);

    // Byte lanes on page[2].
    wr(REG_DATA, 16'h01F5, 2'b11);
    wr(REG_DATA, 16'hAB55, 2'b01);
    rd_chk("lane_lo", REG_DATA, 16'h0155);
    wr(REG_DATA, 16'hFFFF, 2'b00);
    rd_chk("lane_none", REG_DATA, 16'h0155);
    wr(REG_DATA, 16'h0055, 2'b10);
    rd_chk("lane_hi", REG_DATA, 16'h0055);
    wr(REG_ID, 16'hFFFF, 2'b11);
    rd_chk("id_ro", REG_ID, 16'h2204);

    // Unmapped page and out-of-window identity.
    wr(REG_INDEX, 16'h0001, 2'b11);
    wr(REG_DATA, 16'h01FF, 2'b11);
    translate("tr_unmapped", 20'hD4000, 32'h00000000, 1'b1);
    translate("tr_outwin", 20'hE4000, 32'h000E4000, 1'b0);

    // Translation concurrent with a page[0] write, then back-to-back request.
    wr(REG_INDEX, 16'h0000, 2'b11);
    ba = 20'hD0004;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_adr_i = REG_DATA; bus.wb_dat_i = 16'h00AA; bus.wb_sel_i = 2'b11;
    bus.tr_req_i = 1'b1; bus.tr_adr_i = ba[19:1];
    @(posedge wb_clk); #1;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    chk("sim_wb_ack", 32'(bus.wb_ack_o), 32'd1);
    chk("sim_tr_ack", 32'(bus.tr_ack_o), 32'd1);
    chk("sim_old_pfn", bus.tr_adr_o, 32'h00044004);
    @(posedge wb_clk); #1;
    bus.tr_req_i = 1'b0;
    chk("b2b_tr_ack", 32'(bus.tr_ack_o), 32'd1);
    chk("b2b_new_pfn", bus.tr_adr_o, 32'h002A8004);
    chk("b2b_wb_ack", 32'(bus.wb_ack_o), 32'd0);
    @(posedge wb_clk); #1;
    chk("hold_ack", 32'(bus.tr_ack_o), 32'd0);
    chk("hold_adr", bus.tr_adr_o, 32'h002A8004);

    // Reset while a write strobe and a translation are pending.
    wr(REG_INDEX, 16'h0003, 2'b11);
    ba = 20'hD8010;
    wb_rst = 1'b1;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_adr_i = REG_DATA; bus.wb_dat_i = 16'h0077; bus.wb_sel_i = 2'b11;
    bus.tr_req_i = 1'b1; bus.tr_adr_i = ba[19:1];
    @(posedge wb_clk); #1;
    chk("mid_rst_wb_ack",   32'(bus.wb_ack_o),   32'd0);
    chk("mid_rst_tr_ack",   32'(bus.tr_ack_o),   32'd0);
    chk("mid_rst_tr_adr",   bus.tr_adr_o,        32'd0);
    chk("mid_rst_tr_fault", 32'(bus.tr_fault_o), 32'd0);
    @(posedge wb_clk); #1;
    chk("mid_rst_wb_ack2",  32'(bus.wb_ack_o),   32'd0);
    wb_rst = 1'b0;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.tr_req_i = 1'b0;
    @(posedge wb_clk); #1;
    rd_chk("post_rst_ctrl", REG_CTRL, 16'h0000);
    rd_chk("post_rst_index", REG_INDEX, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      wr(REG_INDEX, 16'(i), 2'b11);
      rd_chk($sformatf("post_rst_page_%0d", i), REG_DATA, 16'(i));
    end
    translate("post_rst_tr", 20'hD8010, 32'h000D8010, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
